// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set-2 receiver and held-key bitmap decoder
//
// Purpose: conditions the raw PS/2 clock/data pads, receives 11-bit frames
// (start, 8 data LSB first, odd parity, stop), and decodes make/break codes
// into an 8-bit held-key bitmap. Bit order: W A S D L F1 F2 F3 = bits 0..7.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   ps2_clk       in   raw PS/2 clock pad (asynchronous)
//   ps2_data      in   raw PS/2 data pad (asynchronous)
//   keyboard_data out  held-key bitmap, 1 = pressed
//   scan_code     out  last byte received with good framing and parity
//   scan_valid    out  one-cycle pulse when scan_code updates
//   frame_err     out  one-cycle pulse on parity/stop error or timeout
//
// Optional feature macro: PS2_FKEY_TOGGLE_EN (F1..F3 become toggle bits that
// flip on a make only after a break has re-armed them).

module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboard_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PAR, R_STOP} rx_state_t;
  typedef enum logic [1:0] {D_BASE, D_BRK, D_EXT, D_EXT_BRK} dec_state_t;

  logic [1:0]    clk_sync, data_sync;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt, clk_filt_q;
  logic          fall, sample;

  rx_state_t     r_state, r_next;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [WW-1:0] wd_cnt;
  logic          timeout, byte_ok, rx_err;

  dec_state_t    d_state, d_next;
  logic [7:0]    kb_next;
  logic          key_hit;
  logic [2:0]    key_idx;

  // Input conditioning: 2-FF synchronizers, then a glitch filter that only
  // follows the synchronized clock after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_filt_q <= clk_filt;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall    = clk_filt_q & ~clk_filt;
  assign sample  = data_sync[1];
  // A fall in the same cycle as expiry wins: the keyboard is still talking.
  assign timeout = (r_state != R_IDLE) && !fall && (wd_cnt == WW'(TIMEOUT_CYC - 1));

  always_comb begin
    r_next    = r_state;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    byte_ok   = 1'b0;
    rx_err    = 1'b0;
    if (timeout) begin
      r_next = R_IDLE;
      rx_err = 1'b1;
    end else if (fall) begin
      case (r_state)
        R_IDLE: begin
          if (!sample) begin
            r_next    = R_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        R_DATA: begin
          shift_d   = {sample, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) r_next = R_PAR;
        end
        R_PAR: begin
          par_d  = sample;
          r_next = R_STOP;
        end
        R_STOP: begin
          r_next = R_IDLE;
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (sample && (^{shift_q, par_q})) byte_ok = 1'b1;
          else                               rx_err  = 1'b1;
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= R_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      wd_cnt     <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_state    <= r_next;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      scan_valid <= byte_ok;
      frame_err  <= rx_err;
      if (byte_ok) scan_code <= shift_q;
      if (r_state == R_IDLE || fall) wd_cnt <= '0;
      else                           wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Scancode to bitmap position.
  always_comb begin
    key_hit = 1'b1;
    key_idx = 3'd0;
    case (shift_q)
      8'h1D:   key_idx = 3'd0;
      8'h1C:   key_idx = 3'd1;
      8'h1B:   key_idx = 3'd2;
      8'h23:   key_idx = 3'd3;
      8'h4B:   key_idx = 3'd4;
      8'h05:   key_idx = 3'd5;
      8'h06:   key_idx = 3'd6;
      8'h04:   key_idx = 3'd7;
      default: key_hit = 1'b0;
    endcase
  end

`ifdef PS2_FKEY_TOGGLE_EN
  logic [2:0] armed, armed_next;
  logic       is_fkey;
  logic [1:0] fidx;
  assign is_fkey = (key_idx >= 3'd5);
  assign fidx    = 2'(key_idx - 3'd5);
`endif

  // The decoder is fed by the byte being accepted this cycle so that
  // keyboard_data lands in the same cycle as the scan_valid pulse.
  always_comb begin
    d_next  = d_state;
    kb_next = keyboard_data;
`ifdef PS2_FKEY_TOGGLE_EN
    armed_next = armed;
`endif
    if (byte_ok) begin
      case (d_state)
        D_BASE: begin
          if (shift_q == 8'hF0)      d_next = D_BRK;
          else if (shift_q == 8'hE0) d_next = D_EXT;
          else if (key_hit) begin
`ifdef PS2_FKEY_TOGGLE_EN
            if (is_fkey) begin
              if (armed[fidx]) begin
                kb_next[key_idx] = ~keyboard_data[key_idx];
                armed_next[fidx] = 1'b0;
              end
            end else begin
              kb_next[key_idx] = 1'b1;
            end
`else
            kb_next[key_idx] = 1'b1;
`endif
          end
        end
        D_BRK: begin
          d_next = D_BASE;
          if (key_hit) begin
`ifdef PS2_FKEY_TOGGLE_EN
            if (is_fkey) armed_next[fidx] = 1'b1;
            else         kb_next[key_idx] = 1'b0;
`else
            kb_next[key_idx] = 1'b0;
`endif
          end
        end
        D_EXT:     d_next = (shift_q == 8'hF0) ? D_EXT_BRK : D_BASE;
        D_EXT_BRK: d_next = D_BASE;
        default:   d_next = D_BASE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_state       <= D_BASE;
      keyboard_data <= '0;
`ifdef PS2_FKEY_TOGGLE_EN
      armed         <= 3'b111;
`endif
    end else begin
      d_state       <= d_next;
      keyboard_data <= kb_next;
`ifdef PS2_FKEY_TOGGLE_EN
      armed         <= armed_next;
`endif
    end
  end

endmodule
